receiver: RTL and testbench
===========================

# receiver

Receiving end of the 16-bit Request/Ack word link driven by `sender`. Captures each word presented with `Request`, acknowledges it with a one-cycle `Ack` pulse and buffers it in a small first-word-fall-through FIFO for the local consumer. When the FIFO is full, the block withholds `Ack`, which stalls the sender.

## Interface
- `WIDTH`, 16, data word width
- `DEPTH`, 4, FIFO depth in words; must be a power of two, ≥ 2
- `ADDR_W`, 2, log2(`DEPTH`)

Ports:
- `clk` input 1: single clock; all signals are synchronous to its rising edge
- `Reset` input 1: synchronous, active-high reset
- `Request` input 1: sender has a valid word on `rcvDataIn`
- `rcvDataIn` input `WIDTH`: word from the sender; stable while `Request`=1
- `Ack` output 1: one-cycle pulse confirming that the word was captured
- `Read` input 1: consumer pops the head word (honoured only when `Valid`=1)
- `Valid` output 1: FIFO is non-empty
- `rcvDataOut` output `WIDTH`: head word while `Valid`=1, else 0
- `Full` output 1: FIFO holds `DEPTH` words
- `Count` output `ADDR_W+1`: number of words currently stored (0..`DEPTH`)

## Operation
- Link state machine, three states:
  - IDLE: `Ack`=0. On an edge with `Request`=1 and `Full`=0, write `rcvDataIn` into the FIFO and go to ACK. With `Request`=1 and `Full`=1, stay in IDLE; the word is neither written nor acked.
  - ACK: `Ack`=1. Always go to WAIT_LOW on the next edge.
  - WAIT_LOW: `Ack`=0. Go to IDLE on the first edge where `Request`=0. A `Request` still held high is never captured twice.
- `Ack` is a registered output and is high only in ACK.
- FIFO: circular buffer with `rd_ptr` and `wr_ptr` (`ADDR_W` bits each), both wrapping from `DEPTH-1` to 0, plus a `Count` register.
  - Write when the IDLE capture condition holds.
  - Pop when `Read`=1 and `Valid`=1. A `Read` while empty is ignored, with no pointer or `Count` change.
  - Simultaneous write and pop: both pointers advance and `Count` is unchanged.
  - `Full` is derived from the `Count` value at the start of the cycle. A pop in the same cycle does not unblock a write; the capture happens one cycle later.
- `Valid` = (`Count` != 0). `Full` = (`Count` == `DEPTH`).
- `rcvDataOut` = `Valid` ? mem[`rd_ptr`] : 0.
- Storage memory is not reset; all control state is reset.

## Timing
- Reset, on an edge with `Reset`=1:
  - state = IDLE; `Ack`=0; `rd_ptr`=`wr_ptr`=0; `Count`=0.
  - Therefore `Valid`=0, `Full`=0, `rcvDataOut`=0.
- `Reset` has priority over all other inputs.
- Reset mid-handshake (in ACK or WAIT_LOW):
  - `Ack` is 0 after the reset edge and buffered words are discarded.
  - If `Request` is still high after reset, that word is captured as new on the first non-reset edge.
- Capture latency: `Request` is sampled high in IDLE at edge N. After edge N, `Ack`=1, `Count` is incremented and `Valid`=1 (if previously empty). After edge N+1, `Ack`=0.
- Throughput:
  - Minimum 3 cycles per word (IDLE→ACK→WAIT_LOW→IDLE), when the sender drops `Request` in the cycle after `Ack`.
  - The sender may hold `Request` longer. The receiver stays in WAIT_LOW indefinitely until `Request` falls.
- Pop latency: `Read`=1 with `Valid`=1 at edge N. The next word (or 0 and `Valid`=0) is on `rcvDataOut` after edge N.
- `Count` changes by at most ±1 per cycle.
- Pointer wrap-around is transparent to ordering: words leave in exact arrival order.

## Test plan
- Reset check: assert `Reset` for 2 cycles. Required: `Ack`=0, `Valid`=0, `Full`=0, `Count`=0, `rcvDataOut`=0.
- Single word: `Request`=1 with 16'h1000 for one cycle, then 0. Required: one `Ack` pulse exactly 1 cycle after the sample edge; `Count`=1; `rcvDataOut`=16'h1000. After `Read`=1 for one cycle: `Valid`=0, `rcvDataOut`=0.
- Held request: hold `Request`=1 with 16'h2222 for 6 cycles. Required: exactly one `Ack` pulse and `Count`=1. After `Request` drops, the state is IDLE.
- Backpressure and wrap, with the bench's sender model and `Read`=0:
  - Send 16'h1000+i for i = 0..16 (17 words).
  - Required after 4 words: `Full`=1, `Count`=4, and no further `Ack`.
  - Then pop one word per cycle continuously.
  - Required: all 17 words come out in order 16'h1000..16'h1010, with none lost or duplicated across pointer wrap.
- Simultaneous pop and write: with `Count`=2, capture a word and assert `Read`=1 in the same cycle. Required: `Count` stays 2 and the head advances. Also, with `Full`=1, `Read` and `Request` in the same cycle: the write is captured one cycle later.
- Reset mid-handshake: `Reset`=1 in the cycle where `Ack`=1 with 2 words buffered. Required: `Ack`=0, `Count`=0, `Valid`=0 after the edge. With `Request` still high, the word is recaptured and acked 2 cycles later.

Source files
------------

// File: rtl/receiver.sv
// receiver: Request/Ack word link endpoint with a FWFT FIFO for the consumer.
// Ports: clk, Reset, Request/rcvDataIn/Ack (link), Read/Valid/rcvDataOut/Full/Count (consumer).
module receiver #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Request,
  input  logic [WIDTH-1:0]  rcvDataIn,
  output logic              Ack,
  input  logic              Read,
  output logic              Valid,
  output logic [WIDTH-1:0]  rcvDataOut,
  output logic              Full,
  output logic [ADDR_W:0]   Count
);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT_LOW
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic              wr_en;
  logic              rd_en;

  assign Valid      = (count_q != '0);
  assign Full       = (count_q == DEPTH_C);
  assign Count      = count_q;
  assign Ack        = (state_q == ACK);
  assign rcvDataOut = Valid ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    state_d = state_q;
    wr_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Full comes from the registered count, so a same-cycle
        // pop cannot make room for this capture.
        if (Request && !Full) begin
          wr_en   = 1'b1;
          state_d = ACK;
        end
      end
      ACK:      state_d = WAIT_LOW;
      WAIT_LOW: if (!Request) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en    = Read && Valid;
    // DEPTH is a power of two, so pointer overflow is the wrap.
    wr_ptr_d = wr_ptr_q + ADDR_W'(wr_en);
    rd_ptr_d = rd_ptr_q + ADDR_W'(rd_en);
    count_d  = count_q;
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= rcvDataIn;
  end

endmodule

// File: tb/tb_receiver.sv
// tb_receiver: directed bench for receiver with a queue scoreboard.
// Drives and samples on the falling edge, away from the active edge.
module tb_receiver;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Request;
  logic [15:0] rcvDataIn;
  logic        Ack;
  logic        Read;
  logic        Valid;
  logic [15:0] rcvDataOut;
  logic        Full;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;
  logic [15:0] sb [$];

  receiver #(.WIDTH(16), .DEPTH(4), .ADDR_W(2)) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Request    (Request),
    .rcvDataIn  (rcvDataIn),
    .Ack        (Ack),
    .Read       (Read),
    .Valid      (Valid),
    .rcvDataOut (rcvDataOut),
    .Full       (Full),
    .Count      (Count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_word(input logic [15:0] d);
    Request   = 1'b1;
    rcvDataIn = d;
    sb.push_back(d);
  endtask

  // Waits (bounded) for the Ack pulse, then drops Request and
  // spends the two cycles needed to return the link to IDLE.
  task automatic wait_ack(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (Ack !== 1'b1 && n < 200);
    check(tag, Ack, 1);
    Request = 1'b0;
    tick();
    tick();
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    e = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    check({tag, "_valid"}, Valid, 1);
    check({tag, "_data"}, rcvDataOut, e);
    Read = 1'b1;
    tick();
    Read = 1'b0;
  endtask

  initial begin
    int acks;
    int popped;
    int n;
    Reset     = 1'b1;
    Request   = 1'b0;
    Read      = 1'b0;
    rcvDataIn = '0;
    tick();
    tick();
    check("rst_ack", Ack, 0);
    check("rst_valid", Valid, 0);
    check("rst_full", Full, 0);
    check("rst_count", Count, 0);
    check("rst_data", rcvDataOut, 0);
    Reset = 1'b0;
    tick();

    // Single word
    drive_word(16'h1000);
    tick();
    check("single_ack", Ack, 1);
    check("single_count", Count, 1);
    Request = 1'b0;
    tick();
    check("single_ack_low", Ack, 0);
    tick();
    pop_check("single_pop");
    check("single_empty_valid", Valid, 0);
    check("single_empty_data", rcvDataOut, 0);

    // Held request: one Ack only
    drive_word(16'h2222);
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (Ack === 1'b1) acks++;
    end
    check("held_acks", acks, 1);
    check("held_count", Count, 1);
    Request = 1'b0;
    tick();
    drive_word(16'h2223);
    tick();
    check("held_idle_ack", Ack, 1);
    Request = 1'b0;
    tick();
    tick();
    check("held_count2", Count, 2);
    pop_check("held_pop0");
    pop_check("held_pop1");

    // Backpressure and wrap
    for (int i = 0; i < 4; i++) begin
      drive_word(16'h1000 + 16'(i));
      wait_ack("bp_fill_ack");
    end
    check("bp_full", Full, 1);
    check("bp_count", Count, 4);
    drive_word(16'h1004);
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (Ack === 1'b1) acks++;
    end
    check("bp_no_ack", acks, 0);
    popped = 0;
    fork
      begin
        wait_ack("bp_ack4");
        for (int i = 5; i < 17; i++) begin
          drive_word(16'h1000 + 16'(i));
          wait_ack("bp_ack");
        end
      end
      begin
        n = 0;
        while (popped < 17 && n < 400) begin
          if (Valid === 1'b1) begin
            pop_check("bp_pop");
            popped++;
          end else begin
            tick();
          end
          n++;
        end
      end
    join
    check("bp_popped", popped, 17);
    check("bp_sb_empty", sb.size(), 0);
    check("bp_drained", Valid, 0);

    // Simultaneous pop and write at Count=2
    drive_word(16'h3000);
    wait_ack("sim_ack0");
    drive_word(16'h3001);
    wait_ack("sim_ack1");
    check("sim_count2", Count, 2);
    check("sim_head0", rcvDataOut, sb.pop_front());
    drive_word(16'h3002);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("sim_ack", Ack, 1);
    check("sim_count_hold", Count, 2);
    check("sim_head1", rcvDataOut, sb[0]);
    Request = 1'b0;
    tick();
    tick();

    // Full with Read and Request together
    drive_word(16'h3003);
    wait_ack("full_ack0");
    drive_word(16'h3004);
    wait_ack("full_ack1");
    check("full_full", Full, 1);
    check("full_head", rcvDataOut, sb.pop_front());
    drive_word(16'h3005);
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("full_no_ack", Ack, 0);
    check("full_count3", Count, 3);
    tick();
    check("full_late_ack", Ack, 1);
    check("full_count4", Count, 4);
    Request = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) pop_check("full_pop");
    check("full_drained", Valid, 0);

    // Reset mid-handshake
    drive_word(16'h4000);
    wait_ack("mid_ack0");
    drive_word(16'h4001);
    tick();
    check("mid_ack1", Ack, 1);
    check("mid_count2", Count, 2);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("mid_rst_ack", Ack, 0);
    check("mid_rst_count", Count, 0);
    check("mid_rst_valid", Valid, 0);
    sb.delete();
    sb.push_back(16'h4001);
    tick();
    check("mid_reack", Ack, 1);
    check("mid_recount", Count, 1);
    Request = 1'b0;
    tick();
    tick();
    pop_check("mid_pop");

    // Read while empty is ignored
    Read = 1'b1;
    tick();
    Read = 1'b0;
    check("empty_read_count", Count, 0);
    check("empty_read_valid", Valid, 0);
    drive_word(16'h5000);
    wait_ack("post_empty_ack");
    pop_check("post_empty_pop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
